// File: rtl/sbox_cfg_pkg.sv
// Shared constants, FSM state type and entry-to-pin mapping for the switch box config loader.
// SBOX_CRC_EN adds the CRC state to the FSM encoding.
package sbox_cfg_pkg;

    localparam int          N_TB_DEFAULT = 5;
    localparam int          N_LR_DEFAULT = 4;
    localparam int          ENTRY_BITS   = 6;
    localparam int          N_ENTRIES    = 18;
    localparam logic [7:0]  HDR_DEFAULT  = 8'hA5;

    localparam logic [2:0]  SIDE_OFF    = 3'd0;
    localparam logic [2:0]  SIDE_TOP    = 3'd1;
    localparam logic [2:0]  SIDE_RIGHT  = 3'd2;
    localparam logic [2:0]  SIDE_BOTTOM = 3'd3;
    localparam logic [2:0]  SIDE_LEFT   = 3'd4;

`ifdef SBOX_CRC_EN
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_CRC, ST_COMMIT, ST_DONE} cfg_state_e;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_COMMIT, ST_DONE} cfg_state_e;
`endif

    typedef struct packed {
        logic [2:0] side;
        logic [2:0] pin;
    } pin_loc_t;

    // Entry order: top pins, bottom pins, left pins, right pins.
    function automatic pin_loc_t entry_loc(input int k, input int n_tb, input int n_lr);
        pin_loc_t loc;
        if (k < n_tb) begin
            loc.side = SIDE_TOP;
            loc.pin  = 3'(k);
        end else if (k < 2*n_tb) begin
            loc.side = SIDE_BOTTOM;
            loc.pin  = 3'(k - n_tb);
        end else if (k < 2*n_tb + n_lr) begin
            loc.side = SIDE_LEFT;
            loc.pin  = 3'(k - 2*n_tb);
        end else begin
            loc.side = SIDE_RIGHT;
            loc.pin  = 3'(k - 2*n_tb - n_lr);
        end
        return loc;
    endfunction

endpackage

// File: rtl/sbox_entry_check.sv
// Combinational legality check of one routing entry byte against the pin it configures.
module sbox_entry_check
    import sbox_cfg_pkg::*;
#(
    parameter int N_TB  = 5,
    parameter int N_LR  = 4,
    parameter int IDX_W = 5
) (
    input  logic [7:0]       data_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             illegal_o
);

    logic [2:0] src_side;
    logic [2:0] src_pin;
    pin_loc_t   own;

    assign src_side = data_i[2:0];
    assign src_pin  = data_i[5:3];
    assign own      = entry_loc(int'(idx_i), N_TB, N_LR);

    always_comb begin
        illegal_o = 1'b0;
        if (data_i[7:6] != 2'b00) illegal_o = 1'b1;
        case (src_side)
            SIDE_OFF: ;
            SIDE_TOP, SIDE_BOTTOM: if (int'(src_pin) >= N_TB) illegal_o = 1'b1;
            SIDE_LEFT, SIDE_RIGHT: if (int'(src_pin) >= N_LR) illegal_o = 1'b1;
            default:               illegal_o = 1'b1;
        endcase
        // A pin routed from itself would close a combinational loop in the matrix.
        if (src_side != SIDE_OFF && src_side == own.side && src_pin == own.pin)
            illegal_o = 1'b1;
    end

endmodule

// File: rtl/sbox_cfg_loader.sv
// Byte-stream configuration loader: validates a full frame into a shadow bank, then commits atomically.
// Define SBOX_CRC_EN to require a trailing CRC-8 (poly 0x07, init 0x00) over header and entries.
//
// state  | meaning
// IDLE   | drop non-header bytes, wait for HDR
// LOAD   | write entry bytes into shadow, flag illegal ones
// CRC    | check trailing CRC byte (SBOX_CRC_EN only)
// COMMIT | copy shadow to active_cfg, or raise cfg_err
// DONE   | one dead cycle before returning to IDLE
module sbox_cfg_loader
    import sbox_cfg_pkg::*;
#(
    parameter int         N_TB    = 5,
    parameter int         N_LR    = 4,
    parameter int         ENTRY_W = 6,
    parameter logic [7:0] HDR     = 8'hA5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [7:0]                        cfg_data,
    output logic [ENTRY_W*(2*N_TB+2*N_LR)-1:0] active_cfg,
    output logic                              cfg_commit,
    output logic                              cfg_busy,
    output logic                              cfg_err
);

    localparam int N_ENT = 2*N_TB + 2*N_LR;
    localparam int CNT_W = $clog2(N_ENT);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ENT - 1);

    cfg_state_e                     state_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [ENTRY_W-1:0]             shadow_q [N_ENT];
    logic [ENTRY_W*N_ENT-1:0]       active_q;
    logic                           ready_q;
    logic                           commit_q;
    logic                           busy_q;
    logic                           err_q;
    logic                           bad_q;
    logic                           accept;
    logic                           entry_illegal;

`ifdef SBOX_CRC_EN
    logic [7:0] crc_q;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction
`endif

    assign accept = cfg_valid && ready_q;

    sbox_entry_check #(
        .N_TB  (N_TB),
        .N_LR  (N_LR),
        .IDX_W (CNT_W)
    ) u_check (
        .data_i    (cfg_data),
        .idx_i     (cnt_q),
        .illegal_o (entry_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            active_q <= '0;
            ready_q  <= 1'b0;
            commit_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            bad_q    <= 1'b0;
            for (int k = 0; k < N_ENT; k++) shadow_q[k] <= '0;
`ifdef SBOX_CRC_EN
            crc_q    <= '0;
`endif
        end else begin
            commit_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept && cfg_data == HDR) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        bad_q   <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef SBOX_CRC_EN
                        crc_q   <= crc8_step(8'h00, cfg_data);
`endif
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        shadow_q[cnt_q] <= cfg_data[ENTRY_W-1:0];
                        if (entry_illegal) bad_q <= 1'b1;
`ifdef SBOX_CRC_EN
                        crc_q <= crc8_step(crc_q, cfg_data);
`endif
                        if (cnt_q == LAST_IDX) begin
`ifdef SBOX_CRC_EN
                            state_q <= ST_CRC;
`else
                            state_q <= ST_COMMIT;
                            ready_q <= 1'b0;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
`ifdef SBOX_CRC_EN
                ST_CRC: begin
                    if (accept) begin
                        if (cfg_data != crc_q) bad_q <= 1'b1;
                        state_q <= ST_COMMIT;
                        ready_q <= 1'b0;
                    end
                end
`endif
                ST_COMMIT: begin
                    if (!bad_q) begin
                        for (int k = 0; k < N_ENT; k++)
                            active_q[k*ENTRY_W +: ENTRY_W] <= shadow_q[k];
                        commit_q <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cfg_ready  = ready_q;
    assign active_cfg = active_q;
    assign cfg_commit = commit_q;
    assign cfg_busy   = busy_q;
    assign cfg_err    = err_q;

endmodule

// File: tb/tb_sbox_cfg_loader.sv
// Scoreboard bench for sbox_cfg_loader: frames push expected outcomes, a negedge monitor checks them.
module tb_sbox_cfg_loader;

    localparam logic [7:0] HDR = 8'hA5;
`ifdef SBOX_CRC_EN
    localparam int FRAME_LEN = 20;
`else
    localparam int FRAME_LEN = 19;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [7:0]   cfg_data;
    logic [107:0] active_cfg;
    logic         cfg_commit;
    logic         cfg_busy;
    logic         cfg_err;

    sbox_cfg_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .active_cfg (active_cfg),
        .cfg_commit (cfg_commit),
        .cfg_busy   (cfg_busy),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           commit;
        logic [107:0] active;
        bit           err;
    } exp_t;

    exp_t         exp_q[$];
    logic [7:0]   fr [18];
    logic [107:0] model_active = '0;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           final_edge = -10;
    int           nbytes = 0;

    task automatic chk(input string nm, input logic [107:0] act, input logic [107:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: frame tracking from observed handshakes, checks around each frame's final byte.
    always @(negedge clk) begin
        exp_t me;
        if (rst_n) begin
            if (cyc == final_edge) chk("ready_in_commit", {107'b0, cfg_ready}, 108'd0);
            if (cyc == final_edge + 1) begin
                chk("ready_in_done", {107'b0, cfg_ready}, 108'd0);
                chk("busy_in_done", {107'b0, cfg_busy}, 108'd1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard_empty: frame ended with no expectation queued");
                end else begin
                    me = exp_q.pop_front();
                    chk("commit_pulse", {107'b0, cfg_commit}, {107'b0, me.commit});
                    chk("active_cfg", active_cfg, me.active);
                    chk("cfg_err", {107'b0, cfg_err}, {107'b0, me.err});
                end
            end else if (cfg_commit) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_commit: commit at edge %0d, expected edge %0d", cyc, final_edge + 1);
            end
            if (cyc == final_edge + 2) begin
                chk("ready_back_idle", {107'b0, cfg_ready}, 108'd1);
                chk("busy_back_idle", {107'b0, cfg_busy}, 108'd0);
            end
            if (cfg_valid && cfg_ready) begin
                if (!cfg_busy) begin
                    if (cfg_data == HDR) nbytes = 1;
                end else begin
                    nbytes++;
                    if (nbytes == FRAME_LEN) final_edge = cyc + 1;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        if (gap) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        end
        cfg_data  = b;
        cfg_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!cfg_ready) begin
            n++;
            if (n > 50) begin
                $display("FAIL ready_timeout: cfg_ready low for %0d cycles, expected high", n);
                $fatal(1, "ready timeout");
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
    endtask

    task automatic send_frame(input bit bad, input bit gap, input bit crc_bad);
        exp_t e;
`ifdef SBOX_CRC_EN
        logic [7:0] crc;
`endif
        if (!bad && !crc_bad)
            for (int k = 0; k < 18; k++) model_active[k*6 +: 6] = fr[k][5:0];
        e.commit = !(bad || crc_bad);
        e.active = model_active;
        e.err    = bad || crc_bad;
        exp_q.push_back(e);
        send_byte(HDR, gap);
`ifdef SBOX_CRC_EN
        crc = crc8(8'h00, HDR);
`endif
        for (int k = 0; k < 18; k++) begin
            send_byte(fr[k], gap);
`ifdef SBOX_CRC_EN
            crc = crc8(crc, fr[k]);
`endif
        end
`ifdef SBOX_CRC_EN
        send_byte(crc_bad ? (crc ^ 8'h5A) : crc, gap);
`endif
    endtask

    task automatic clear_fr();
        for (int k = 0; k < 18; k++) fr[k] = 8'h00;
    endtask

    task automatic legal_mix();
        clear_fr();
        fr[0]  = 8'h02;
        fr[1]  = 8'h38;
        fr[5]  = 8'h01;
        fr[9]  = 8'h21;
        fr[13] = 8'h1A;
        fr[14] = 8'h21;
        fr[17] = 8'h1C;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {107'b0, cfg_ready}, 108'd0);
        chk("rst_active", active_cfg, 108'd0);
        chk("rst_commit", {107'b0, cfg_commit}, 108'd0);
        chk("rst_busy", {107'b0, cfg_busy}, 108'd0);
        chk("rst_err", {107'b0, cfg_err}, 108'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {107'b0, cfg_ready}, 108'd1);

        clear_fr();
        send_frame(1'b0, 1'b0, 1'b0);

        legal_mix();
        send_frame(1'b0, 1'b0, 1'b0);

        legal_mix();
        fr[5] = 8'h03;
        send_frame(1'b1, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("err_sticky_idle", {107'b0, cfg_err}, 108'd1);

        clear_fr();
        fr[3]  = 8'h0C;
        fr[16] = 8'h13;
        send_frame(1'b0, 1'b0, 1'b0);

        clear_fr();
        fr[10] = 8'h24;
        fr[3]  = 8'h47;
        send_frame(1'b1, 1'b0, 1'b0);

        clear_fr();
        fr[10] = 8'h24;
        send_frame(1'b1, 1'b0, 1'b0);

        clear_fr();
        fr[3] = 8'h47;
        send_frame(1'b1, 1'b0, 1'b0);

        clear_fr();
        fr[0] = 8'h05;
        send_frame(1'b1, 1'b0, 1'b0);

        clear_fr();
        fr[6] = 8'h29;
        send_frame(1'b1, 1'b0, 1'b0);

        send_byte(8'h3C, 1'b0);
        chk("stray_dropped", {107'b0, cfg_busy}, 108'd0);
        legal_mix();
        fr[7] = HDR;
        send_frame(1'b1, 1'b1, 1'b0);

        send_byte(8'h3C, 1'b1);
        clear_fr();
        fr[0]  = 8'h04;
        fr[1]  = 8'h0B;
        fr[12] = 8'h0A;
        send_frame(1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        legal_mix();
        send_byte(HDR, 1'b0);
        for (int k = 0; k < 9; k++) send_byte(fr[k], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_active", active_cfg, 108'd0);
        chk("midrst_ready", {107'b0, cfg_ready}, 108'd0);
        chk("midrst_busy", {107'b0, cfg_busy}, 108'd0);
        model_active = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(1'b0, 1'b0, 1'b0);

`ifdef SBOX_CRC_EN
        clear_fr();
        fr[2] = 8'h02;
        send_frame(1'b0, 1'b0, 1'b1);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 108'(exp_q.size()), 108'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
